// File: rtl/hash_table_pkg.sv
// rtl/hash_table_pkg.sv - shared hash table types: address width, free-pool FSM states, error record
package hash_table_pkg;

  localparam int TABLE_ADDR_WIDTH = 8;

  typedef enum logic {
    FRESH_S   = 1'b0,
    RECYCLE_S = 1'b1
  } pool_state_e;

  typedef struct packed {
    logic underflow;
    logic overflow;
    logic double_free;
  } free_pool_err_t;

endpackage

// File: rtl/free_addr_fifo.sv
// rtl/free_addr_fifo.sv - show-ahead FIFO holding recycled addresses
module free_addr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_tvalid,
  input  logic [WIDTH-1:0] in_tdata,
  input  logic             out_tready,
  output logic [WIDTH-1:0] out_tdata,
  output logic             out_tvalid
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign pop        = out_tready && (count != '0);
  assign push       = in_tvalid && ((count != CW'(DEPTH)) || pop);
  assign out_tdata  = mem[rd_ptr];
  assign out_tvalid = (count != '0);

  // Storage array; no reset needed, validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_tdata;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/free_addr_pool.sv
// rtl/free_addr_pool.sv - free address pool; optional FREE_ADDR_POOL_DOUBLE_FREE_CHECK_EN bitmap check
module free_addr_pool
  import hash_table_pkg::*;
#(
  parameter int A_WIDTH = TABLE_ADDR_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic [A_WIDTH-1:0] empty_addr_o,
  output logic               empty_addr_val_o,
  input  logic               empty_addr_rd_ack_i,
  input  logic [A_WIDTH-1:0] add_addr_i,
  input  logic               add_addr_val_i,
  output logic [A_WIDTH:0]   free_cnt_o,
  output logic               err_underflow_o,
  output logic               err_overflow_o
`ifdef FREE_ADDR_POOL_DOUBLE_FREE_CHECK_EN
  ,
  output logic               err_double_free_o
`endif
);

  localparam int                 N         = 2 ** A_WIDTH;
  localparam logic [A_WIDTH:0]   CNT_FULL  = (A_WIDTH + 1)'(N);
  localparam logic [A_WIDTH-1:0] LAST_ADDR = A_WIDTH'(N - 1);

  pool_state_e        state_q;
  pool_state_e        state_d;
  logic [A_WIDTH-1:0] fresh_ptr_q;
  logic [A_WIDTH:0]   free_cnt_q;
  logic [A_WIDTH-1:0] fifo_head;
  logic               fifo_valid;
  logic               fresh_pop;
  logic               fifo_pop;
  logic               ack_ok;
  logic               add_ok;
  logic               full;

  assign empty_addr_val_o = (free_cnt_q != '0);
  assign free_cnt_o       = free_cnt_q;
  assign full             = (free_cnt_q == CNT_FULL);
  assign ack_ok           = empty_addr_rd_ack_i && empty_addr_val_o;

`ifdef FREE_ADDR_POOL_DOUBLE_FREE_CHECK_EN
  logic [N-1:0] alloc_q;

  // Only addresses currently handed out may come back.
  assign add_ok = add_addr_val_i && (!full || ack_ok) && alloc_q[add_addr_i];

  // Allocation bitmap and double-free flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alloc_q           <= '0;
      err_double_free_o <= 1'b0;
    end else begin
      if (ack_ok) alloc_q[empty_addr_o] <= 1'b1;
      if (add_ok) alloc_q[add_addr_i]   <= 1'b0;
      if (add_addr_val_i && !alloc_q[add_addr_i]) err_double_free_o <= 1'b1;
    end
  end
`else
  assign add_ok = add_addr_val_i && (!full || ack_ok);
`endif

  // Recycled addresses, returned in arrival order.
  free_addr_fifo #(
    .WIDTH (A_WIDTH),
    .DEPTH (N)
  ) u_fifo (
    .clk        (clk_i),
    .rst        (rst_i),
    .in_tvalid  (add_ok),
    .in_tdata   (add_addr_i),
    .out_tready (fifo_pop),
    .out_tdata  (fifo_head),
    .out_tvalid (fifo_valid)
  );

  // State register: once the fresh range is spent only reset goes back.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= FRESH_S;
    else       state_q <= state_d;
  end

  // Next state, address source select and consume strobes.
  always_comb begin
    state_d      = state_q;
    fresh_pop    = 1'b0;
    fifo_pop     = 1'b0;
    empty_addr_o = fifo_head;
    case (state_q)
      FRESH_S: begin
        empty_addr_o = fresh_ptr_q;
        fresh_pop    = ack_ok;
        if (ack_ok && (fresh_ptr_q == LAST_ADDR)) state_d = RECYCLE_S;
      end
      RECYCLE_S: begin
        fifo_pop = ack_ok && fifo_valid;
      end
      default: state_d = FRESH_S;
    endcase
  end

  // Fresh pointer holds at N-1 so it never wraps after exhaustion.
  always_ff @(posedge clk_i) begin
    if (rst_i)                                       fresh_ptr_q <= '0;
    else if (fresh_pop && (fresh_ptr_q != LAST_ADDR)) fresh_ptr_q <= fresh_ptr_q + 1'b1;
  end

  // Free count and sticky error flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      free_cnt_q      <= CNT_FULL;
      err_underflow_o <= 1'b0;
      err_overflow_o  <= 1'b0;
    end else begin
      case ({add_ok, ack_ok})
        2'b10:   free_cnt_q <= free_cnt_q + 1'b1;
        2'b01:   free_cnt_q <= free_cnt_q - 1'b1;
        default: free_cnt_q <= free_cnt_q;
      endcase
      if (empty_addr_rd_ack_i && !empty_addr_val_o) err_underflow_o <= 1'b1;
      if (add_addr_val_i && full && !ack_ok)         err_overflow_o  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_free_addr_pool.sv
// tb/tb_free_addr_pool.sv - directed table, corner sequences and randomized model check for free_addr_pool
module tb_free_addr_pool;

  localparam int AW = 3;
  localparam int N  = 8;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [AW-1:0] empty_addr_o;
  logic          empty_addr_val_o;
  logic          empty_addr_rd_ack_i = 1'b0;
  logic [AW-1:0] add_addr_i = '0;
  logic          add_addr_val_i = 1'b0;
  logic [AW:0]   free_cnt_o;
  logic          err_underflow_o;
  logic          err_overflow_o;
  logic          err_double_free_o;

  free_addr_pool #(.A_WIDTH(AW)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .empty_addr_o        (empty_addr_o),
    .empty_addr_val_o    (empty_addr_val_o),
    .empty_addr_rd_ack_i (empty_addr_rd_ack_i),
    .add_addr_i          (add_addr_i),
    .add_addr_val_i      (add_addr_val_i),
    .free_cnt_o          (free_cnt_o),
    .err_underflow_o     (err_underflow_o),
    .err_overflow_o      (err_overflow_o)
`ifdef FREE_ADDR_POOL_DOUBLE_FREE_CHECK_EN
    ,
    .err_double_free_o   (err_double_free_o)
`endif
  );

`ifndef FREE_ADDR_POOL_DOUBLE_FREE_CHECK_EN
  assign err_double_free_o = 1'b0;
`endif

  always #5 clk_i = ~clk_i;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    bit r, a, av;
    int aa;
    bit ev;
    int ea, ec;
    bit euf, eof;
  } vec_t;

  vec_t vecs[$];

  // Reference: free addresses as an ordered list; fresh ones sit in front initially.
  int q[$];
  bit alloc[N];
  bit m_uf, m_of, m_df;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < N; i++) begin
      q.push_back(i);
      alloc[i] = 1'b0;
    end
    m_uf = 1'b0; m_of = 1'b0; m_df = 1'b0;
  endtask

  task automatic model_step(input bit r, input bit a, input bit av, input int aa);
    bit val, ack_ok, full, add_ok;
    if (r) begin
      model_reset();
      return;
    end
    val    = (q.size() != 0);
    ack_ok = a && val;
    full   = (q.size() == N);
    if (a && !val) m_uf = 1'b1;
    if (av && full && !ack_ok) m_of = 1'b1;
    add_ok = av && (!full || ack_ok);
`ifdef FREE_ADDR_POOL_DOUBLE_FREE_CHECK_EN
    if (av && !alloc[aa]) m_df = 1'b1;
    add_ok = add_ok && alloc[aa];
`endif
    if (ack_ok) begin
      alloc[q[0]] = 1'b1;
      void'(q.pop_front());
    end
    if (add_ok) begin
      alloc[aa] = 1'b0;
      q.push_back(aa);
    end
  endtask

  task automatic drive(input bit r, input bit a, input bit av, input int aa);
    rst_i               = r;
    empty_addr_rd_ack_i = a;
    add_addr_val_i      = av;
    add_addr_i          = aa[AW-1:0];
    @(posedge clk_i);
    model_step(r, a, av, aa);
    @(negedge clk_i);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".val"}, empty_addr_val_o, (q.size() != 0));
    chk({tag, ".cnt"}, free_cnt_o, q.size());
    if (q.size() != 0) chk({tag, ".addr"}, empty_addr_o, q[0]);
    chk({tag, ".uf"}, err_underflow_o, m_uf);
    chk({tag, ".of"}, err_overflow_o, m_of);
    chk({tag, ".df"}, err_double_free_o, m_df);
  endtask

  task automatic tv(input bit r, input bit a, input bit av, input int aa,
                    input bit ev, input int ea, input int ec, input bit euf, input bit eof);
    vec_t v;
    v.r = r; v.a = a; v.av = av; v.aa = aa;
    v.ev = ev; v.ea = ea; v.ec = ec; v.euf = euf; v.eof = eof;
    vecs.push_back(v);
  endtask

  initial begin
    model_reset();

    // reset state, overflow on a full pool, reset clears flags
    tv(1,0,0,0, 1,0,8,0,0);
    tv(0,0,1,3, 1,0,8,0,1);
    tv(1,0,0,0, 1,0,8,0,0);
    // eight back-to-back acks drain the fresh range
    for (int i = 0; i < N; i++) tv(0,1,0,0, (i < N-1), i+1, N-1-i, 0,0);
    // ack while empty
    tv(0,1,0,0, 0,0,0,1,0);
    // recycled addresses leave in arrival order
    tv(0,0,1,5, 1,5,1,1,0);
    tv(0,0,1,2, 1,5,2,1,0);
    tv(0,1,0,0, 1,2,1,1,0);
    tv(0,1,0,0, 0,0,0,1,0);
    // simultaneous ack and add with one free entry
    tv(0,0,1,4, 1,4,1,1,0);
    tv(0,1,1,6, 1,6,1,1,0);
    tv(0,1,0,0, 0,0,0,1,0);
    // reset mid-stream ignores ack/add in that cycle
    tv(1,1,1,3, 1,0,8,0,0);
    // returned address queues behind the remaining fresh ones
    tv(0,1,0,0, 1,1,7,0,0);
    tv(0,1,0,0, 1,2,6,0,0);
    tv(0,1,0,0, 1,3,5,0,0);
    tv(0,0,1,1, 1,3,6,0,0);
    tv(0,1,0,0, 1,4,5,0,0);
    tv(0,1,0,0, 1,5,4,0,0);
    tv(0,1,0,0, 1,6,3,0,0);
    tv(0,1,0,0, 1,7,2,0,0);
    tv(0,1,0,0, 1,1,1,0,0);
    tv(0,1,0,0, 0,0,0,0,0);

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].a, vecs[i].av, vecs[i].aa);
      chk($sformatf("v%0d.val", i), empty_addr_val_o, vecs[i].ev);
      chk($sformatf("v%0d.cnt", i), free_cnt_o, vecs[i].ec);
      if (vecs[i].ev) chk($sformatf("v%0d.addr", i), empty_addr_o, vecs[i].ea);
      chk($sformatf("v%0d.uf", i), err_underflow_o, vecs[i].euf);
      chk($sformatf("v%0d.of", i), err_overflow_o, vecs[i].eof);
    end

    // refill an exhausted pool in reverse order, then ack+add while full
    drive(1, 0, 0, 0);
    for (int i = 0; i < N; i++) drive(0, 1, 0, 0);
    for (int i = 0; i < N; i++) begin
      drive(0, 0, 1, N-1-i);
      check_model($sformatf("fill%0d", i));
    end
    chk("fill.head", empty_addr_o, 7);
    drive(0, 1, 1, 2);
    check_model("full_ackadd");
    chk("full_ackadd.next", empty_addr_o, 6);
    drive(0, 0, 1, 0);
    check_model("full_add");

`ifdef FREE_ADDR_POOL_DOUBLE_FREE_CHECK_EN
    // returning a never-allocated address is dropped
    drive(1, 0, 0, 0);
    drive(0, 0, 1, 6);
    chk("dfree.flag", err_double_free_o, 1);
    chk("dfree.cnt", free_cnt_o, 8);
`endif

    // randomized traffic against the reference list
    drive(1, 0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 299) == 0,
            $urandom_range(0, 99) < 55,
            $urandom_range(0, 99) < 50,
            $urandom_range(0, N-1));
      check_model($sformatf("rnd%0d", c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
